// File: rtl/spi_master_param.sv
// Purpose : parameterised SPI master; one DATA_W-bit MSB-first frame per accepted start, all four SPI modes, N_SLV chip-selects.
// Latency : done pulses 1+(2*DATA_W+2)*CLK_DIV clk cycles after the start cycle; rx_data is valid in that same cycle.
// Backpr. : start is sampled only while idle (busy=0), so a start seen while busy is dropped. An out-of-range slv_sel gives an err pulse.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               transfer request (idle only)
//   slv_sel, mode       target chip-select index, SPI mode {CPOL,CPHA}
//   tx_data / rx_data   frame to send / last received frame
//   busy, done, err     frame in progress, frame completion pulse, bad slv_sel pulse
//   sclk, mosi, miso    serial clock / data out / data in
//   cs_n                active-low one-hot chip-selects
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int N_SLV   = 3,
  parameter int CLK_DIV = 2,
  parameter int SEL_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  slv_sel,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [N_SLV-1:0]  cs_n
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HP_W  = $clog2(2 * DATA_W);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  // Index of the last XFER half-period and the one before it.
  localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);
  localparam logic [HP_W-1:0]  HP_PEN   = HP_W'(2 * DATA_W - 2);
  localparam logic [SEL_W:0]   N_SLV_V  = (SEL_W + 1)'(N_SLV);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  div_cnt;   // clk cycles within the current half-period
  logic [HP_W-1:0]   hp_cnt;    // XFER half-period index
  logic [1:0]        mode_q;    // {CPOL, CPHA} for the frame in flight
  logic [DATA_W-1:0] tx_sh;     // bits still to be presented on mosi
  logic [DATA_W-1:0] rx_sh;     // bits sampled so far
  logic [N_SLV-1:0]  cs_dec;

  logic sel_ok;
  logic accept;
  logic reject;
  logic tick;
  logic lead_edge;
  logic trail_edge;
  logic last_trail;
  logic shift_evt;
  logic sample_evt;
  logic frame_end;

  // ---------------------------------------------------------------
  // Next-state logic and per-cycle event strobes.
  // lead_edge/trail_edge mark the clk edge on which sclk moves away
  // from / back to CPOL; all shifting and sampling keys off these.
  // ---------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    sel_ok     = ({1'b0, slv_sel} < N_SLV_V);
    accept     = 1'b0;
    reject     = 1'b0;
    tick       = (div_cnt == CNT_LAST);
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    frame_end  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            accept    = 1'b1;
            state_nxt = SETUP;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      SETUP: begin
        // The first XFER half-period opens with the first leading edge.
        if (tick) begin
          state_nxt = XFER;
          lead_edge = 1'b1;
        end
      end
      XFER: begin
        if (tick) begin
          if (hp_cnt == HP_LAST) begin
            state_nxt = HOLD;
          end else if (hp_cnt[0]) begin
            // Moving into an even half-period: a leading edge.
            lead_edge = 1'b1;
          end else begin
            trail_edge = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    last_trail = trail_edge && (hp_cnt == HP_PEN);

    // CPHA=0: first bit is already on mosi before any edge, later bits
    //         move on trailing edges (not after the final one), sample on leading.
    // CPHA=1: each leading edge presents the next bit, sample on trailing.
    shift_evt  = mode_q[0] ? lead_edge  : (trail_edge && !last_trail);
    sample_evt = mode_q[0] ? trail_edge : lead_edge;
  end

  // One-hot active-low decode of the requested slave.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < N_SLV; i++) begin
      cs_dec[i] = (slv_sel != SEL_W'(i));
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      hp_cnt  <= '0;
      mode_q  <= 2'b00;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= '1;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= frame_end;
      err  <= reject;

      // Half-period divider runs in every non-idle state and restarts
      // at each state change, since those coincide with tick.
      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end

      if (state != XFER) begin
        hp_cnt <= '0;
      end else if (tick) begin
        hp_cnt <= hp_cnt + HP_W'(1);
      end

      if (accept) begin
        mode_q <= mode;
        cs_n   <= cs_dec;
        sclk   <= mode[1];
        rx_sh  <= '0;
        if (mode[0]) begin
          // CPHA=1: nothing is driven until the first leading edge.
          tx_sh <= tx_data;
          mosi  <= 1'b0;
        end else begin
          tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
          mosi  <= tx_data[DATA_W-1];
        end
      end

      if (lead_edge || trail_edge) begin
        sclk <= ~sclk;
      end

      if (shift_evt) begin
        mosi  <= tx_sh[DATA_W-1];
        tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
      end

      if (sample_evt) begin
        rx_sh <= {rx_sh[DATA_W-2:0], miso};
      end

      if (frame_end) begin
        cs_n    <= '1;
        mosi    <= 1'b0;
        sclk    <= mode_q[1];
        rx_data <= rx_sh;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Purpose : directed, table-driven bench for spi_master_param (default build plus a 16-bit/5-slave/div-3 build).
// Latency : checks done at start+1+(2*DATA_W+2)*CLK_DIV for both builds.
// Backpr. : checks that a start seen while busy is ignored and that a start held high gives back-to-back frames.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Default build: DATA_W=8, N_SLV=3, CLK_DIV=2, SEL_W=2
  logic       start0, busy0, done0, err0, sclk0, mosi0, miso0;
  logic [1:0] sel0, mode0;
  logic [7:0] tx0, rx0;
  logic [2:0] cs0;

  // Wide build: DATA_W=16, N_SLV=5, CLK_DIV=3, SEL_W=3
  logic        start1, busy1, done1, err1, sclk1, mosi1, miso1;
  logic [2:0]  sel1;
  logic [1:0]  mode1;
  logic [15:0] tx1, rx1;
  logic [4:0]  cs1;

  spi_master_param u0 (
    .clk(clk), .reset(reset), .start(start0), .slv_sel(sel0), .mode(mode0),
    .tx_data(tx0), .rx_data(rx0), .busy(busy0), .done(done0), .err(err0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs0)
  );

  spi_master_param #(.DATA_W(16), .N_SLV(5), .CLK_DIV(3), .SEL_W(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .slv_sel(sel1), .mode(mode1),
    .tx_data(tx1), .rx_data(rx1), .busy(busy1), .done(done1), .err(err1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mode-0 slave model for u0: presents slave_word MSB first, advancing
  // after each trailing sclk edge, or echoes mosi when loop is set.
  logic       loop;
  logic [7:0] slave_word;
  logic       cpol_l;
  logic       sprev;
  int         bitn;

  assign miso0 = loop ? mosi0 : ((bitn < 8) ? slave_word[3'(7 - bitn)] : 1'b0);
  assign miso1 = mosi1;

  always @(negedge clk) begin
    if (!busy0) begin
      bitn  <= 0;
      sprev <= sclk0;
    end else begin
      if (sclk0 != sprev && sclk0 == cpol_l) bitn <= bitn + 1;
      sprev <= sclk0;
    end
  end

  typedef struct {
    logic [1:0] mode;
    logic [1:0] sel;
    logic [7:0] tx;
    logic       loop;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [2:0] exp_cs;
  } vec_t;

  localparam int LAT0 = 1 + (2 * 8 + 2) * 2;     // 37
  localparam int LOW0 = (2 * 8 + 2) * 2;         // 36
  localparam int PER1 = 1 + (2 * 16 + 2) * 3;    // 103

  // One complete frame on u0 with cycle-by-cycle observation.
  task automatic run_vec(input int idx, input vec_t v);
    int         lat, lows, leads, trails;
    logic [7:0] cap, rx_before;
    logic       prev, cs_bad, rx_bad, err_seen;
    @(negedge clk);
    start0 = 1'b1; sel0 = v.sel; mode0 = v.mode; tx0 = v.tx;
    loop = v.loop; slave_word = v.slave; cpol_l = v.mode[1];
    rx_before = rx0;
    @(negedge clk);
    // Input changes after acceptance must not reach the frame.
    start0 = 1'b0; sel0 = ~v.sel; mode0 = ~v.mode; tx0 = ~v.tx;
    chk($sformatf("v%0d setup_sclk", idx), 32'(sclk0), 32'(v.mode[1]));
    lat = 0; lows = 0; leads = 0; trails = 0; cap = 8'h00;
    cs_bad = 1'b0; rx_bad = 1'b0; err_seen = 1'b0; prev = sclk0;
    for (int c = 1; c <= 100; c++) begin
      if (done0) begin
        lat = c;
        break;
      end
      if (cs0 !== v.exp_cs || !busy0) cs_bad = 1'b1;
      else lows++;
      if (rx0 !== rx_before) rx_bad = 1'b1;
      if (err0) err_seen = 1'b1;
      if (sclk0 != prev) begin
        if (sclk0 != v.mode[1]) begin
          leads++;
          if (!v.mode[0]) cap = {cap[6:0], mosi0};
        end else begin
          trails++;
          if (v.mode[0]) cap = {cap[6:0], mosi0};
        end
      end
      prev = sclk0;
      @(negedge clk);
    end
    chk($sformatf("v%0d done_latency", idx), 32'(lat), 32'(LAT0));
    chk($sformatf("v%0d cs_low_cycles", idx), 32'(lows), 32'(LOW0));
    chk($sformatf("v%0d cs_pattern", idx), 32'(cs_bad), 32'(0));
    chk($sformatf("v%0d lead_edges", idx), 32'(leads), 32'(8));
    chk($sformatf("v%0d trail_edges", idx), 32'(trails), 32'(8));
    chk($sformatf("v%0d mosi_bits", idx), 32'(cap), 32'(v.tx));
    chk($sformatf("v%0d rx_hold_busy", idx), 32'(rx_bad), 32'(0));
    chk($sformatf("v%0d no_err", idx), 32'(err_seen), 32'(0));
    chk($sformatf("v%0d rx_data", idx), 32'(rx0), 32'(v.exp_rx));
    chk($sformatf("v%0d busy_at_done", idx), 32'(busy0), 32'(0));
    chk($sformatf("v%0d cs_at_done", idx), 32'(cs0), 32'(3'b111));
    chk($sformatf("v%0d mosi_at_done", idx), 32'(mosi0), 32'(0));
    chk($sformatf("v%0d sclk_idle", idx), 32'(sclk0), 32'(v.mode[1]));
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done0), 32'(0));
    chk($sformatf("v%0d rx_hold_idle", idx), 32'(rx0), 32'(v.exp_rx));
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{2'd0, 2'd1, 8'hA5, 1'b0, 8'h3C, 8'h3C, 3'b101};
    tbl[1] = '{2'd0, 2'd0, 8'h81, 1'b1, 8'h00, 8'h81, 3'b110};
    tbl[2] = '{2'd1, 2'd2, 8'h81, 1'b1, 8'h00, 8'h81, 3'b011};
    tbl[3] = '{2'd2, 2'd1, 8'h81, 1'b1, 8'h00, 8'h81, 3'b101};
    tbl[4] = '{2'd3, 2'd0, 8'h81, 1'b1, 8'h00, 8'h81, 3'b110};

    reset = 1'b1;
    start0 = 1'b1; sel0 = 2'd1; mode0 = 2'd3; tx0 = 8'hFF;
    start1 = 1'b0; sel1 = 3'd0; mode1 = 2'd0; tx1 = 16'h0000;
    loop = 1'b1; slave_word = 8'h00; cpol_l = 1'b0;

    // Reset state, with start held during reset.
    repeat (3) @(negedge clk);
    chk("rst cs_n", 32'(cs0), 32'(3'b111));
    chk("rst sclk", 32'(sclk0), 32'(0));
    chk("rst mosi", 32'(mosi0), 32'(0));
    chk("rst busy", 32'(busy0), 32'(0));
    chk("rst done", 32'(done0), 32'(0));
    chk("rst err", 32'(err0), 32'(0));
    chk("rst rx", 32'(rx0), 32'(0));
    chk("rst cs_n wide", 32'(cs1), 32'(5'h1F));
    start0 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

    // Out-of-range select: err pulse, nothing latched.
    @(negedge clk);
    start0 = 1'b1; sel0 = 2'd3; mode0 = 2'd0; tx0 = 8'h77;
    @(negedge clk);
    start0 = 1'b0;
    chk("badsel err", 32'(err0), 32'(1));
    chk("badsel busy", 32'(busy0), 32'(0));
    chk("badsel cs_n", 32'(cs0), 32'(3'b111));
    chk("badsel sclk", 32'(sclk0), 32'(1));
    @(negedge clk);
    chk("badsel err_pulse", 32'(err0), 32'(0));
    chk("badsel busy2", 32'(busy0), 32'(0));

    // Reset 10 cycles into a CPOL=1 frame, with start also high.
    start0 = 1'b1; sel0 = 2'd2; mode0 = 2'd3; tx0 = 8'h5A; cpol_l = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort busy_before", 32'(busy0), 32'(1));
    reset = 1'b1; start0 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start0 = 1'b0;
    chk("abort cs_n", 32'(cs0), 32'(3'b111));
    chk("abort sclk", 32'(sclk0), 32'(0));
    chk("abort busy", 32'(busy0), 32'(0));
    chk("abort done", 32'(done0), 32'(0));
    chk("abort rx", 32'(rx0), 32'(0));
    chk("abort mosi", 32'(mosi0), 32'(0));
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (done0 || busy0) seen = 1'b1;
      end
      chk("abort quiet", 32'(seen), 32'(0));
    end

    // Wide build with start held: back-to-back frames.
    begin
      int         done_at[3];
      logic [15:0] rx_at[3];
      int         lf[3];
      int         n_done, rise2, gap;
      logic       pb, ps, bad_cs, err_seen;
      n_done = 0; rise2 = 0; gap = 0; bad_cs = 1'b0; err_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        done_at[k] = 0; rx_at[k] = 16'h0; lf[k] = 0;
      end
      @(negedge clk);
      start1 = 1'b1; sel1 = 3'd4; mode1 = 2'd0; tx1 = 16'hBEEF;
      pb = busy1; ps = sclk1;
      for (int c = 1; c <= 320; c++) begin
        @(negedge clk);
        if (done1) begin
          if (n_done < 3) begin
            done_at[n_done] = c;
            rx_at[n_done] = rx1;
            if (cs1 !== 5'h1F || busy1) bad_cs = 1'b1;
          end
          n_done++;
        end else if (busy1) begin
          if (cs1 !== 5'b01111) bad_cs = 1'b1;
        end else if (c <= 3 * PER1) begin
          gap++;
        end
        if (err1) err_seen = 1'b1;
        if (busy1 && !pb && n_done == 1) rise2 = c;
        if (busy1 && pb && sclk1 != ps && sclk1 && n_done < 3) lf[n_done]++;
        ps = sclk1; pb = busy1;
        // Mid-frame: a low/high blip on start and a new tx word.
        if (c == 50) start1 = 1'b0;
        if (c == 52) start1 = 1'b1;
        if (c == 60) tx1 = 16'h1234;
      end
      start1 = 1'b0;
      chk("wide done1", 32'(done_at[0]), 32'(PER1));
      chk("wide done2", 32'(done_at[1]), 32'(2 * PER1));
      chk("wide done3", 32'(done_at[2]), 32'(3 * PER1));
      chk("wide frame2_busy", 32'(rise2), 32'(PER1 + 1));
      chk("wide leads1", 32'(lf[0]), 32'(16));
      chk("wide leads2", 32'(lf[1]), 32'(16));
      chk("wide rx1", 32'(rx_at[0]), 32'(16'hBEEF));
      chk("wide rx2", 32'(rx_at[1]), 32'(16'h1234));
      chk("wide cs_pattern", 32'(bad_cs), 32'(0));
      chk("wide idle_gaps", 32'(gap), 32'(0));
      chk("wide no_err", 32'(err_seen), 32'(0));
      repeat (120) @(negedge clk);
      chk("wide final_idle", 32'(busy1), 32'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
